// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM states and helpers for the HI/LO multiply/divide unit.
// Opcode values follow the MIPS SPECIAL funct field.
package muldiv_unit_pkg;

   localparam logic [5:0] ALU_MULT  = 6'b011000;
   localparam logic [5:0] ALU_MULTU = 6'b011001;
   localparam logic [5:0] ALU_DIV   = 6'b011010;
   localparam logic [5:0] ALU_DIVU  = 6'b011011;
   localparam logic [5:0] ALU_MTHI  = 6'b010001;
   localparam logic [5:0] ALU_MTLO  = 6'b010011;

   localparam int DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on magnitudes, one quotient bit per step.
// Sign correction is applied on the outputs from the latched sign flags.
module div_radix2
   import muldiv_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        step_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        neg_q_i,
   input  logic        neg_r_i,
   output logic        done_o,
   output logic [31:0] quo_o,
   output logic [31:0] rem_o
);

   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;

   logic [32:0] shl;
   logic [31:0] diff;
   logic        ge;

   always_comb begin
      shl    = {rem_q, quo_q[31]};
      ge     = shl >= {1'b0, dvs_q};
      // shl < 2*dvs, so the difference always fits in 32 bits when ge
      diff   = shl[31:0] - dvs_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (start_i) begin
         quo_d  = a_i;
         rem_d  = '0;
         dvs_d  = b_i;
         cnt_d  = '0;
         negq_d = neg_q_i;
         negr_d = neg_r_i;
      end else if (step_i) begin
         quo_d = {quo_q[30:0], ge};
         rem_d = ge ? diff : shl[31:0];
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

   assign done_o = step_i & (cnt_q == 5'(DIV_CYCLES - 1));
   assign quo_o  = negq_q ? (~quo_q + 32'd1) : quo_q;
   assign rem_o  = negr_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-step iterative DIV/DIVU that holds the pipeline while it runs.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  ALUControl,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   md_state_e   state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        issue;
   logic        is_mult, is_multu, is_div, is_divu;
   logic        is_mthi, is_mtlo;
   logic        div_go, div_step, div_done, done_wr;
   logic [63:0] prod_s, prod_u;
   logic [31:0] dvd, dvs, quo, rem;
   logic        neg_q, neg_r;

   assign is_mult  = ALUControl == ALU_MULT;
   assign is_multu = ALUControl == ALU_MULTU;
   assign is_div   = ALUControl == ALU_DIV;
   assign is_divu  = ALUControl == ALU_DIVU;
   assign is_mthi  = ALUControl == ALU_MTHI;
   assign is_mtlo  = ALUControl == ALU_MTLO;

   assign issue  = valid_i & ~flush_i & ~stall_i & (state_q == ST_IDLE);
   assign div_go = issue & (is_div | is_divu) & (|b_i);

   // Low 64 bits of the sign-extended product equal the signed product
   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   assign dvd   = is_div ? abs32(a_i) : a_i;
   assign dvs   = is_div ? abs32(b_i) : b_i;
   assign neg_q = is_div & (a_i[31] ^ b_i[31]);
   assign neg_r = is_div & a_i[31];

   div_radix2 u_div (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (div_go),
      .step_i  (div_step),
      .a_i     (dvd),
      .b_i     (dvs),
      .neg_q_i (neg_q),
      .neg_r_i (neg_r),
      .done_o  (div_done),
      .quo_o   (quo),
      .rem_o   (rem)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (div_go) state_d = ST_RUN;
         ST_RUN: begin
            if (flush_i)       state_d = ST_IDLE;
            else if (div_done) state_d = ST_DONE;
         end
         ST_DONE: if (flush_i | ~stall_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      div_step = (state_q == ST_RUN) & ~flush_i;
      stall_o  = div_go | div_step;
      done_wr  = (state_q == ST_DONE) & ~flush_i & ~stall_i;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (1'b1)
         issue & is_mult:  {hi_d, lo_d} = prod_s;
         issue & is_multu: {hi_d, lo_d} = prod_u;
         issue & is_mthi:  hi_d = a_i;
         issue & is_mtlo:  lo_d = a_i;
         done_wr: begin
            hi_d = rem;
            lo_d = quo;
         end
         default: ;
      endcase
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule
